// File: rtl/fir_pkg.sv
// Shared sizing defaults and FSM state codes for the FIR load sequencer.
// Loader and ring pointer both import these so the defaults live in one place.
package fir_pkg;

    localparam int FIR_DATA_W = 16;
    localparam int FIR_TAPS   = 64;
    localparam int FIR_ADDR_W = 6;
    localparam int FIR_OVF_W  = 8;

    typedef logic [1:0] fsm_state_t;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_COEF_LOAD  = 2'd1;
    localparam logic [1:0] ST_SAMPLE_RUN = 2'd2;

endpackage

// File: rtl/fir_ring_ptr.sv
// Circular write pointer for the sample ring plus a fill count that saturates
// at TAPS, so the loader knows when the window first becomes complete.
module fir_ring_ptr
    import fir_pkg::*;
#(
    parameter int ADDR_W = FIR_ADDR_W,
    parameter int TAPS   = FIR_TAPS
)
(
    input  logic              clk_10kHz,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [ADDR_W-1:0] ptr,
    output logic [ADDR_W:0]   fill
);

    // TAPS is a power of two, so the pointer wraps by plain overflow.
    always_ff @(posedge clk_10kHz or posedge reset) begin
        if (reset) begin
            ptr  <= '0;
            fill <= '0;
        end else if (clr) begin
            ptr  <= '0;
            fill <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
            if (fill != (ADDR_W+1)'(TAPS)) begin
                fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_load_sequencer.sv
// Loads a coefficient set into FIR coefficient memory, then streams samples into
// the circular sample buffer, flagging frame_start once the window is full.
module fir_load_sequencer
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int TAPS   = FIR_TAPS,
    parameter int ADDR_W = FIR_ADDR_W,
    parameter int OVF_W  = FIR_OVF_W
)
(
    input  logic              clk_10kHz,
    input  logic              reset,
    input  logic              coef_valid,
    input  logic [DATA_W-1:0] coef_data,
    output logic              coef_ready,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    output logic              smp_ready,
    input  logic              fifo_full,
    input  logic              reload,
    output logic [DATA_W-1:0] cin,
    output logic [ADDR_W-1:0] caddr,
    output logic              cload,
    output logic [DATA_W-1:0] xin,
    output logic [ADDR_W-1:0] xaddr,
    output logic              xload,
    output logic              frame_start,
    output logic              coef_done,
    output logic [OVF_W-1:0]  drop_cnt
);

    fsm_state_t        state;
    logic [ADDR_W-1:0] ccnt;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W:0]   fill;
    logic              coef_acc;
    logic              smp_acc;
    logic              smp_drop;

    // Both streams use valid/ready: a word transfers on an edge where valid and
    // ready are high together; ready depends only on state (and fifo_full).
    assign coef_ready = (state == ST_COEF_LOAD);
    assign smp_ready  = (state == ST_SAMPLE_RUN) & ~fifo_full;
    assign coef_acc   = coef_valid & coef_ready;
    assign smp_acc    = smp_valid & smp_ready;
    assign smp_drop   = smp_valid & fifo_full & (state == ST_SAMPLE_RUN);

    fir_ring_ptr #(
        .ADDR_W (ADDR_W),
        .TAPS   (TAPS)
    ) u_ring (
        .clk_10kHz (clk_10kHz),
        .reset     (reset),
        .inc       (smp_acc),
        .clr       (1'b0),
        .ptr       (wptr),
        .fill      (fill)
    );

    always_ff @(posedge clk_10kHz or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ccnt        <= '0;
            cin         <= '0;
            caddr       <= '0;
            cload       <= 1'b0;
            xin         <= '0;
            xaddr       <= '0;
            xload       <= 1'b0;
            frame_start <= 1'b0;
            coef_done   <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            cload       <= 1'b0;
            xload       <= 1'b0;
            frame_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state <= ST_COEF_LOAD;
                end
                ST_COEF_LOAD: begin
                    // A reload restarts the set; a word arriving with it is lost.
                    if (reload) begin
                        ccnt <= '0;
                    end else if (coef_acc) begin
                        cin   <= coef_data;
                        caddr <= ccnt;
                        cload <= 1'b1;
                        ccnt  <= ccnt + 1'b1;
                        if (ccnt == ADDR_W'(TAPS - 1)) begin
                            coef_done <= 1'b1;
                            state     <= ST_SAMPLE_RUN;
                        end
                    end
                end
                ST_SAMPLE_RUN: begin
                    if (smp_acc) begin
                        xin         <= smp_data;
                        xaddr       <= wptr;
                        xload       <= 1'b1;
                        frame_start <= (fill >= (ADDR_W+1)'(TAPS - 1));
                    end
                    if (smp_drop && (drop_cnt != {OVF_W{1'b1}})) begin
                        drop_cnt <= drop_cnt + 1'b1;
                    end
                    // Ring position and fill survive a reload so old samples stay valid.
                    if (reload) begin
                        ccnt      <= '0;
                        coef_done <= 1'b0;
                        state     <= ST_COEF_LOAD;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_load_sequencer.sv
// Bench for fir_load_sequencer: a spec-derived vector table, hand sequences for
// the multi-cycle corners, then random traffic against a counting reference model.
module tb_fir_load_sequencer;
    import fir_pkg::*;

    localparam int DW = 16;
    localparam int T  = 64;
    localparam int AW = 6;
    localparam int OW = 8;

    logic          clk_10kHz = 1'b0;
    logic          reset     = 1'b1;
    logic          coef_valid = 1'b0;
    logic [DW-1:0] coef_data  = '0;
    logic          coef_ready;
    logic          smp_valid  = 1'b0;
    logic [DW-1:0] smp_data   = '0;
    logic          smp_ready;
    logic          fifo_full  = 1'b0;
    logic          reload     = 1'b0;
    logic [DW-1:0] cin;
    logic [AW-1:0] caddr;
    logic          cload;
    logic [DW-1:0] xin;
    logic [AW-1:0] xaddr;
    logic          xload;
    logic          frame_start;
    logic          coef_done;
    logic [OW-1:0] drop_cnt;

    always #5 clk_10kHz = ~clk_10kHz;

    fir_load_sequencer dut (
        .clk_10kHz   (clk_10kHz),
        .reset       (reset),
        .coef_valid  (coef_valid),
        .coef_data   (coef_data),
        .coef_ready  (coef_ready),
        .smp_valid   (smp_valid),
        .smp_data    (smp_data),
        .smp_ready   (smp_ready),
        .fifo_full   (fifo_full),
        .reload      (reload),
        .cin         (cin),
        .caddr       (caddr),
        .cload       (cload),
        .xin         (xin),
        .xaddr       (xaddr),
        .xload       (xload),
        .frame_start (frame_start),
        .coef_done   (coef_done),
        .drop_cnt    (drop_cnt)
    );

    typedef struct {
        logic          cv;
        logic [DW-1:0] cd;
        logic          sv;
        logic [DW-1:0] sd;
        logic          ff;
        logic          e_cload;
        logic [AW-1:0] e_caddr;
        logic          e_xload;
        logic [AW-1:0] e_xaddr;
        logic          e_fs;
        logic          e_done;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: phase 0 idle, 1 loading coefficients, 2 running samples;
    // ring position and window fill come straight from the total samples written.
    int            ph, ncoef, nsamp, ndrop;
    logic [DW-1:0] m_cin, m_xin;
    logic [AW-1:0] m_caddr, m_xaddr;
    logic          m_cload, m_xload, m_fs, m_done;

    task automatic model_reset();
        ph = 0; ncoef = 0; nsamp = 0; ndrop = 0;
        m_cin = '0; m_xin = '0; m_caddr = '0; m_xaddr = '0;
        m_cload = 1'b0; m_xload = 1'b0; m_fs = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_edge();
        m_cload = 1'b0; m_xload = 1'b0; m_fs = 1'b0;
        if (ph == 0) begin
            ph = 1;
        end else if (ph == 1) begin
            if (reload) begin
                ncoef = 0;
            end else if (coef_valid) begin
                m_cin = coef_data; m_caddr = AW'(ncoef); m_cload = 1'b1;
                ncoef++;
                if (ncoef == T) begin
                    m_done = 1'b1; ph = 2; ncoef = 0;
                end
            end
        end else begin
            if (smp_valid && !fifo_full) begin
                m_xin = smp_data; m_xaddr = AW'(nsamp % T); m_xload = 1'b1;
                nsamp++;
                m_fs = (nsamp >= T);
            end else if (smp_valid && fifo_full && ndrop < (1 << OW) - 1) begin
                ndrop++;
            end
            if (reload) begin
                ncoef = 0; m_done = 1'b0; ph = 1;
            end
        end
    endtask

    function automatic logic [63:0] dut_bus();
        return {6'd0, cin, caddr, cload, xin, xaddr, xload, frame_start, coef_done,
                drop_cnt, coef_ready, smp_ready};
    endfunction

    function automatic logic [63:0] exp_bus();
        return {6'd0, m_cin, m_caddr, m_cload, m_xin, m_xaddr, m_xload, m_fs, m_done,
                OW'(ndrop), (ph == 1), (ph == 2) && !fifo_full};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic cv, input logic [DW-1:0] cd, input logic sv,
                          input logic [DW-1:0] sd, input logic ff, input logic rl);
        coef_valid = cv; coef_data = cd; smp_valid = sv; smp_data = sd;
        fifo_full = ff; reload = rl;
    endtask

    task automatic tick();
        @(posedge clk_10kHz);
        model_edge();
        #1;
        check("cycle_outputs", dut_bus(), exp_bus());
    endtask

    // Reset lands between edges so the asynchronous clear is observed immediately.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("reset_outputs", dut_bus(), exp_bus());
        @(posedge clk_10kHz);
        #1;
        reset = 1'b0;
        set_in(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        vec_t v;
        int   xl_seen;
        int   next_addr;

        for (int k = 0; k < T; k++) begin
            v = '{cv: 1'b1, cd: DW'(k), sv: 1'b0, sd: '0, ff: 1'b0,
                  e_cload: 1'b1, e_caddr: AW'(k), e_xload: 1'b0, e_xaddr: '0,
                  e_fs: 1'b0, e_done: (k == T - 1)};
            tbl.push_back(v);
        end
        for (int k = 0; k < T + 2; k++) begin
            v = '{cv: 1'b0, cd: '0, sv: 1'b1, sd: DW'(16'h100 + k), ff: 1'b0,
                  e_cload: 1'b0, e_caddr: '0, e_xload: 1'b1, e_xaddr: AW'(k % T),
                  e_fs: (k >= T - 1), e_done: 1'b1};
            tbl.push_back(v);
        end
        for (int k = 0; k < 2; k++) begin
            v = '{cv: 1'b0, cd: '0, sv: 1'b1, sd: 16'hdead, ff: 1'b1,
                  e_cload: 1'b0, e_caddr: '0, e_xload: 1'b0, e_xaddr: '0,
                  e_fs: 1'b0, e_done: 1'b1};
            tbl.push_back(v);
        end

        model_reset();
        #2;
        do_reset();
        tick();

        // Full coefficient load, then the sample window filling and wrapping.
        foreach (tbl[i]) begin
            set_in(tbl[i].cv, tbl[i].cd, tbl[i].sv, tbl[i].sd, tbl[i].ff, 1'b0);
            tick();
            check("tbl_cload", cload, tbl[i].e_cload);
            if (tbl[i].e_cload) begin
                check("tbl_caddr", caddr, tbl[i].e_caddr);
                check("tbl_cin", cin, tbl[i].cd);
            end
            check("tbl_xload", xload, tbl[i].e_xload);
            if (tbl[i].e_xload) begin
                check("tbl_xaddr", xaddr, tbl[i].e_xaddr);
                check("tbl_xin", xin, tbl[i].sd);
            end
            check("tbl_frame_start", frame_start, tbl[i].e_fs);
            check("tbl_coef_done", coef_done, tbl[i].e_done);
        end

        // Sustained backpressure: no writes, drop counter pins at its maximum.
        xl_seen = 0;
        set_in(1'b0, '0, 1'b1, 16'h0bad, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (xload) xl_seen++;
        end
        check("drop_no_xload", 64'(xl_seen), 64'd0);
        check("drop_saturate", 64'(drop_cnt), 64'd255);
        set_in(1'b0, '0, 1'b1, 16'h0202, 1'b0, 1'b0);
        tick();
        check("resume_xload", xload, 1'b1);
        check("resume_xaddr", 64'(xaddr), 64'd2);

        // Reload on the same edge as the sample written at ring position 10.
        for (int k = 3; k < 10; k++) begin
            set_in(1'b0, '0, 1'b1, DW'(16'h0200 + k), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, '0, 1'b1, 16'h0aaa, 1'b0, 1'b1);
        tick();
        check("reload_xload", xload, 1'b1);
        check("reload_xaddr", 64'(xaddr), 64'd10);
        check("reload_coef_ready", coef_ready, 1'b1);
        for (int k = 0; k < T; k++) begin
            set_in(1'b1, DW'($urandom), 1'b0, '0, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, '0, 1'b1, 16'h0bbb, 1'b0, 1'b0);
        tick();
        check("post_reload_xaddr", 64'(xaddr), 64'd11);
        check("post_reload_frame", frame_start, 1'b1);

        // Reset part-way through a coefficient reload.
        set_in(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        tick();
        for (int k = 0; k < 20; k++) begin
            set_in(1'b1, DW'(16'h0300 + k), 1'b0, '0, 1'b0, 1'b0);
            tick();
        end
        do_reset();
        check("reset_coef_done", coef_done, 1'b0);
        tick();
        set_in(1'b1, 16'h0400, 1'b0, '0, 1'b0, 1'b0);
        tick();
        check("restart_cload", cload, 1'b1);
        check("restart_caddr", 64'(caddr), 64'd0);

        // Gappy coefficient stream: addresses must stay contiguous.
        next_addr = 1;
        for (int i = 0; i < 3 * (T - 1); i++) begin
            set_in((i % 3 == 0), DW'(16'h0400 + next_addr), 1'b0, '0, 1'b0, 1'b0);
            tick();
            if (cload) begin
                check("gap_caddr", 64'(caddr), 64'(next_addr));
                next_addr++;
            end
        end
        check("gap_count", 64'(next_addr), 64'(T));
        check("gap_coef_done", coef_done, 1'b1);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            set_in(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                   DW'($urandom), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 49) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
